// File: rtl/dc_stage_var.sv
// dc_stage_var: runtime-configurable radix-2 delay-commutator for an MDC FFT.
// Reorders a two-lane complex stream into butterfly-ready pairs using a delay
// D = 1 << cur_delay_log2, selectable at reset/flush up to MAX_DELAY.
//
// Stream handshake: there is no backpressure. A beat is accepted on a rising
// edge where in_valid==1, reset==1 and flush==0. out_valid is registered and
// is high for exactly one cycle after each accepting edge once the stage is
// primed. y0/y1 only change on those edges (or are zeroed by reset).
module dc_stage_var #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_DELAY  = 64,
  localparam int LOG_MAX   = $clog2(MAX_DELAY),
  localparam int CW        = (LOG_MAX > 0) ? $clog2(LOG_MAX + 1) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CW-1:0]           delay_log2,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [2*DATA_WIDTH-1:0] x0,
  input  logic [2*DATA_WIDTH-1:0] x1,
  output logic [2*DATA_WIDTH-1:0] y0,
  output logic [2*DATA_WIDTH-1:0] y1,
  output logic                    out_valid,
  output logic [CW-1:0]           cur_delay_log2
);

  localparam int SW = 2 * DATA_WIDTH;
  // Beat counter spans 0..2D-1, so it needs one bit more than log2(MAX_DELAY).
  localparam int KW = LOG_MAX + 1;
  localparam int AW = (LOG_MAX > 0) ? LOG_MAX : 1;

  logic [KW-1:0] r_k;
  logic          r_primed;
  logic [CW-1:0] r_cur;
  logic          r_out_valid;
  logic [SW-1:0] r_y0;
  logic [SW-1:0] r_y1;

  // Two D-deep delay lines: the lower lane (b) before the switch and the top
  // lane after it. Both are circular buffers addressed by k mod D, so a read
  // returns what was written exactly D accepted beats earlier.
  logic [SW-1:0] r_bot_mem [MAX_DELAY];
  logic [SW-1:0] r_top_mem [MAX_DELAY];

  logic [CW-1:0] w_clamped;
  logic [KW-1:0] w_d_val;
  logic [KW-1:0] w_mask_d;
  logic [KW-1:0] w_mask_2d;
  logic [KW-1:0] w_k_next;
  logic          w_at_d;
  logic [AW-1:0] w_addr;
  logic          w_sw;
  logic          w_accept;
  logic          w_emit;
  logic [SW-1:0] w_dly_b;
  logic [SW-1:0] w_dly_top;
  logic [SW-1:0] w_top;
  logic [SW-1:0] w_bot;

  // Delay selection, counter wrap, switch control and lane routing.
  always_comb begin
    w_clamped = delay_log2;
    if (int'(delay_log2) > LOG_MAX) w_clamped = CW'(LOG_MAX);

    w_d_val   = KW'(1) << r_cur;
    w_mask_d  = w_d_val - KW'(1);
    w_mask_2d = (w_mask_d << 1) | KW'(1);
    w_k_next  = (r_k + KW'(1)) & w_mask_2d;
    w_at_d    = (r_k == w_d_val);
    w_addr    = AW'(r_k & w_mask_d);
    w_sw      = r_k[r_cur];

    w_accept  = in_valid & ~flush;
    // Primed-at-this-beat: the first pair leaves on the edge where k reaches D.
    w_emit    = w_accept & (r_primed | w_at_d);

    w_dly_b   = r_bot_mem[w_addr];
    w_dly_top = r_top_mem[w_addr];
    w_top     = w_sw ? w_dly_b : x0;
    w_bot     = w_sw ? x0 : w_dly_b;
  end

  // Delay-line writes; contents are never cleared because nothing stale is
  // emitted before the stage is primed again.
  always_ff @(posedge clk) begin
    if (reset && w_accept) begin
      r_bot_mem[w_addr] <= x1;
      r_top_mem[w_addr] <= w_top;
    end
  end

  // Control state and registered outputs; reset beats flush beats in_valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_k         <= '0;
      r_primed    <= 1'b0;
      r_cur       <= w_clamped;
      r_out_valid <= 1'b0;
      r_y0        <= '0;
      r_y1        <= '0;
    end else if (flush) begin
      r_k         <= '0;
      r_primed    <= 1'b0;
      r_cur       <= w_clamped;
      r_out_valid <= 1'b0;
    end else if (in_valid) begin
      r_k         <= w_k_next;
      r_out_valid <= w_emit;
      if (w_at_d) r_primed <= 1'b1;
      if (w_emit) begin
        r_y0 <= w_dly_top;
        r_y1 <= w_bot;
      end
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign y0             = r_y0;
  assign y1             = r_y1;
  assign out_valid      = r_out_valid;
  assign cur_delay_log2 = r_cur;

endmodule

// File: tb/tb_dc_stage_var.sv
// Testbench for dc_stage_var: scenario tasks drive frames, a reference model
// of the commutated pair order fills an expected queue, and a negedge monitor
// pops and compares every output pair.
module tb_dc_stage_var;

  localparam int W  = 32;
  localparam int SW = 2 * W;
  localparam int PW = 2 * SW;
  localparam int CW = 3;

  // Clock and reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [CW-1:0] delay_log2;
  logic [SW-1:0] x0, x1, y0, y1;
  logic          out_valid;
  logic [CW-1:0] cur_delay_log2;

  dc_stage_var #(.DATA_WIDTH(W), .MAX_DELAY(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .delay_log2     (delay_log2),
    .flush          (flush),
    .in_valid       (in_valid),
    .x0             (x0),
    .x1             (x1),
    .y0             (y0),
    .y1             (y1),
    .out_valid      (out_valid),
    .cur_delay_log2 (cur_delay_log2)
  );

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] last_exp;
  logic [PW-1:0] mon_e;
  int            n_checks = 0;
  int            n_errors = 0;
  bit            chk_imag = 1'b0;
  logic [SW-1:0] fa [256];
  logic [SW-1:0] fb [256];

  function automatic logic [SW-1:0] mk(input logic [W-1:0] r, input logic [W-1:0] i);
    return {r, i};
  endfunction

  // Driver: present one cycle of inputs, return 1 time unit after the edge.
  task automatic drive(input logic v, input logic [SW-1:0] a, input logic [SW-1:0] b,
                       input logic fl);
    in_valid = v;
    x0       = a;
    x1       = b;
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Reference pair order for a frame of len beats (multiple of 2d):
  // per block, D pairs of upper-lane samples then D pairs of lower-lane ones.
  task automatic push_model(input int d, input int len);
    for (int m = 0; m < len / (2 * d); m++) begin
      for (int j = 0; j < d; j++) exp_q.push_back({fa[2*d*m+j], fa[2*d*m+d+j]});
      for (int j = 0; j < d; j++) exp_q.push_back({fb[2*d*m+j], fb[2*d*m+d+j]});
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_pair: got y0=%h y1=%h, required no output", y0, y1);
      end else begin
        mon_e    = exp_q.pop_front();
        last_exp = mon_e;
        if ({y0, y1} !== mon_e) begin
          n_errors++;
          $display("FAIL pair: got y0=%h y1=%h, required y0=%h y1=%h",
                   y0, y1, mon_e[PW-1:SW], mon_e[SW-1:0]);
        end
      end
      if (chk_imag) begin
        n_checks++;
        if (y0[W-1:0] !== W'(-y0[SW-1:W]) || y1[W-1:0] !== W'(-y1[SW-1:W])) begin
          n_errors++;
          $display("FAIL imag_route: got y0=%h y1=%h, required imag == -real", y0, y1);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0; delay_log2 = 3'd0;
    drive(1'b0, '0, '0, 1'b0);
    drive(1'b1, mk(9, 9), mk(9, 9), 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_ov: got %b required 0", out_valid); end
    n_checks++;
    if (y0 !== '0 || y1 !== '0) begin n_errors++; $display("FAIL reset_y: got %h %h required 0 0", y0, y1); end
    n_checks++;
    if (cur_delay_log2 !== 3'd0) begin n_errors++; $display("FAIL reset_cur: got %0d required 0", cur_delay_log2); end
    last_exp = '0;
    reset = 1'b1;
  endtask

  task automatic test_d1();
    for (int i = 0; i < 4; i++) begin
      fa[i] = mk(W'(i), W'($urandom));
      fb[i] = mk(W'(i + 4), W'($urandom));
    end
    push_model(1, 4);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i < 4) ? fa[i] : '0, (i < 4) ? fb[i] : '0, 1'b0);
      n_checks++;
      if (out_valid !== (i >= 1)) begin n_errors++; $display("FAIL d1_ov beat %0d: got %b required %b", i, out_valid, i >= 1); end
    end
    settle();
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL d1_drain: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_d4();
    delay_log2 = 3'd2;
    drive(1'b0, '0, '0, 1'b1);
    n_checks++;
    if (cur_delay_log2 !== 3'd2) begin n_errors++; $display("FAIL d4_cur: got %0d required 2", cur_delay_log2); end
    for (int i = 0; i < 8; i++) begin
      fa[i] = mk(W'(i), W'($urandom));
      fb[i] = mk(W'(i + 8), W'($urandom));
    end
    push_model(4, 8);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, (i < 8) ? fa[i] : '0, (i < 8) ? fb[i] : '0, 1'b0);
      n_checks++;
      if (out_valid !== (i >= 4)) begin n_errors++; $display("FAIL d4_ov beat %0d: got %b required %b", i, out_valid, i >= 4); end
    end
    settle();
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL d4_drain: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_stalls();
    delay_log2 = 3'd2;
    drive(1'b0, '0, '0, 1'b1);
    push_model(4, 8);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, (i < 8) ? fa[i] : '0, (i < 8) ? fb[i] : '0, 1'b0);
      n_checks++;
      if (out_valid !== (i >= 4)) begin n_errors++; $display("FAIL stall_ov beat %0d: got %b required %b", i, out_valid, i >= 4); end
      drive(1'b0, mk(W'($urandom), W'($urandom)), mk(W'($urandom), W'($urandom)), 1'b0);
      n_checks++;
      if (out_valid !== 1'b0 || {y0, y1} !== last_exp) begin
        n_errors++;
        $display("FAIL stall_hold beat %0d: got ov=%b y=%h required ov=0 y=%h", i, out_valid, {y0, y1}, last_exp);
      end
    end
    settle();
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL stall_drain: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_flush_change();
    delay_log2 = 3'd2;
    drive(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      fa[i] = mk(W'($urandom), W'($urandom));
      fb[i] = mk(W'($urandom), W'($urandom));
    end
    exp_q.push_back({fa[0], fa[4]});
    for (int i = 0; i < 5; i++) drive(1'b1, fa[i], fb[i], 1'b0);
    settle();
    delay_log2 = 3'd1;
    drive(1'b1, mk(32'h77, 32'h77), mk(32'h88, 32'h88), 1'b1);
    n_checks++;
    if (cur_delay_log2 !== 3'd1) begin n_errors++; $display("FAIL flush_cur: got %0d required 1", cur_delay_log2); end
    n_checks++;
    if (out_valid !== 1'b0 || {y0, y1} !== last_exp) begin
      n_errors++;
      $display("FAIL flush_hold: got ov=%b y=%h required ov=0 y=%h", out_valid, {y0, y1}, last_exp);
    end
    delay_log2 = 3'd3;
    for (int i = 0; i < 8; i++) begin
      fa[i] = mk(W'($urandom), W'($urandom));
      fb[i] = mk(W'($urandom), W'($urandom));
    end
    push_model(2, 8);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, (i < 8) ? fa[i] : '0, (i < 8) ? fb[i] : '0, 1'b0);
      n_checks++;
      if (out_valid !== (i >= 2)) begin n_errors++; $display("FAIL flush_ov beat %0d: got %b required %b", i, out_valid, i >= 2); end
    end
    n_checks++;
    if (cur_delay_log2 !== 3'd1) begin n_errors++; $display("FAIL flush_cur_hold: got %0d required 1", cur_delay_log2); end
    settle();
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL flush_drain: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    delay_log2 = 3'd1;
    drive(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      fa[i] = mk(W'($urandom), W'($urandom));
      fb[i] = mk(W'($urandom), W'($urandom));
    end
    exp_q.push_back({fa[0], fa[2]});
    for (int i = 0; i < 3; i++) drive(1'b1, fa[i], fb[i], 1'b0);
    settle();
    delay_log2 = 3'd7;
    reset = 1'b0;
    drive(1'b1, mk(W'($urandom), W'($urandom)), mk(W'($urandom), W'($urandom)), 1'b0);
    reset = 1'b1;
    n_checks++;
    if (y0 !== '0 || y1 !== '0 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid: got y0=%h y1=%h ov=%b required 0 0 0", y0, y1, out_valid);
    end
    n_checks++;
    if (cur_delay_log2 !== 3'd6) begin n_errors++; $display("FAIL rst_clamp: got %0d required 6", cur_delay_log2); end
    last_exp = '0;
    for (int i = 0; i < 128; i++) begin
      fa[i] = mk(W'($urandom), W'($urandom));
      fb[i] = mk(W'($urandom), W'($urandom));
    end
    push_model(64, 128);
    for (int i = 0; i < 192; i++) begin
      drive(1'b1, (i < 128) ? fa[i] : '0, (i < 128) ? fb[i] : '0, 1'b0);
      n_checks++;
      if (out_valid !== (i >= 64)) begin n_errors++; $display("FAIL d64_ov beat %0d: got %b required %b", i, out_valid, i >= 64); end
    end
    settle();
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL d64_drain: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_imag();
    logic [W-1:0] rv;
    delay_log2 = 3'd1;
    drive(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      rv = W'($urandom);
      fa[i] = mk(rv, W'(-rv));
      rv = W'($urandom);
      fb[i] = mk(rv, W'(-rv));
    end
    push_model(2, 8);
    chk_imag = 1'b1;
    for (int i = 0; i < 10; i++) drive(1'b1, (i < 8) ? fa[i] : '0, (i < 8) ? fb[i] : '0, 1'b0);
    settle();
    chk_imag = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL imag_drain: got %0d left required 0", exp_q.size()); end
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    delay_log2 = '0; x0 = '0; x1 = '0; last_exp = '0;
    test_reset();
    test_d1();
    test_d4();
    test_stalls();
    test_flush_change();
    test_reset_mid();
    test_imag();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
